// File: rtl/miner_pkg.sv
// Shared types and constants for the SHA-256 compression engine.
// Includes the round constants, the initial hash value, the FSM state type and a rotate helper.
package miner_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } compress_state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/miner_core_round.sv
// One combinational SHA-256 round. The working variables a..h are packed
// a in [255:224] down to h in [31:0], the same layout as the chaining value.
module miner_core_round
  import miner_pkg::*;
(
  input  logic [255:0] work_i,
  input  word_t        k_i,
  input  word_t        w_i,
  output logic [255:0] work_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t s0, s1, ch, maj, t1, t2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = work_i;
    s1  = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
    ch  = (e & f) ^ (~e & g);
    s0  = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + k_i + w_i;
    t2  = s0 + maj;
    work_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/miner_core_compress.sv
// SHA-256 compression engine: one round per accepted schedule word, then a
// feed-forward add into the chaining value and a one-cycle digest_valid pulse.
module miner_core_compress
  import miner_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  compress_state_t state_q, state_d;
  logic [5:0]      round_cnt_q, round_cnt_d;
  logic [255:0]    work_q, work_d;
  logic [255:0]    h_q, h_d;
  logic [255:0]    digest_q, digest_d;
  logic            digest_valid_q, digest_valid_d;
  logic [255:0]    work_next;
  logic            handshake;

  miner_core_round u_round (
    .work_i (work_q),
    .k_i    (K[round_cnt_q]),
    .w_i    (w_data),
    .work_o (work_next)
  );

  assign w_ready      = (state_q == ROUND);
  assign busy         = (state_q != IDLE);
  assign handshake    = w_valid & w_ready;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

  always_comb begin
    state_d        = state_q;
    round_cnt_d    = round_cnt_q;
    work_d         = work_q;
    h_d            = h_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          h_d         = h_in;
          work_d      = h_in;
          round_cnt_d = 6'd0;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        if (handshake) begin
          work_d      = work_next;
          round_cnt_d = round_cnt_q + 6'd1;
          if (round_cnt_q == LAST_ROUND) state_d = FINAL;
        end
      end
      FINAL: begin
        // Feed-forward add is per 32-bit word; carries must not cross word lanes.
        for (int i = 0; i < 8; i++) begin
          digest_d[i*32 +: 32] = h_q[i*32 +: 32] + work_q[i*32 +: 32];
        end
        digest_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      round_cnt_q    <= 6'd0;
      work_q         <= '0;
      h_q            <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_cnt_q    <= round_cnt_d;
      work_q         <= work_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

endmodule
